// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the multi-cycle RISC-V core: opcodes,
// sequencer states and datapath select encodings.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_ITYPE  = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_RTYPE  = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IBUS    = 2'd2;
  localparam logic [1:0] CAUSE_DBUS    = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MULDIV, S_WB, S_TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_TARGET, PC_JALR} pc_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADD, ALU_BRANCH, ALU_RTYPE, ALU_ITYPE, ALU_LUI
  } alu_op_class_e;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode decode: immediate format, ALU operand/class,
// writeback source, and instruction legality.
module ctrl_opcode_decoder
  import multicycle_control_fsm_pkg::*;
#(
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic [6:0]    opcode_i,
  input  logic [6:0]    funct7_i,
  output imm_sel_e      imm_sel_o,
  output logic          alu_src_b_o,
  output alu_op_class_e alu_op_o,
  output wb_sel_e       wb_sel_o,
  output logic          legal_o,
  output logic          muldiv_o
);

  always_comb begin
    imm_sel_o   = IMM_NONE;
    alu_src_b_o = 1'b0;
    alu_op_o    = ALU_NONE;
    wb_sel_o    = WB_ALU;
    legal_o     = 1'b1;
    case (opcode_i)
      OPCODE_RTYPE: alu_op_o = ALU_RTYPE;
      OPCODE_ITYPE: begin imm_sel_o = IMM_I; alu_src_b_o = 1'b1; alu_op_o = ALU_ITYPE; end
      OPCODE_LOAD: begin
        imm_sel_o = IMM_I; alu_src_b_o = 1'b1; alu_op_o = ALU_ADD; wb_sel_o = WB_MEM;
      end
      OPCODE_STORE: begin imm_sel_o = IMM_S; alu_src_b_o = 1'b1; alu_op_o = ALU_ADD; end
      OPCODE_BRANCH: begin imm_sel_o = IMM_B; alu_op_o = ALU_BRANCH; end
      OPCODE_JAL: begin
        imm_sel_o = IMM_J; alu_src_b_o = 1'b1; alu_op_o = ALU_ADD; wb_sel_o = WB_PC4;
      end
      OPCODE_JALR: begin
        imm_sel_o = IMM_I; alu_src_b_o = 1'b1; alu_op_o = ALU_ADD; wb_sel_o = WB_PC4;
      end
      OPCODE_LUI:   begin imm_sel_o = IMM_U; alu_src_b_o = 1'b1; alu_op_o = ALU_LUI; end
      OPCODE_AUIPC: begin imm_sel_o = IMM_U; alu_src_b_o = 1'b1; alu_op_o = ALU_ADD; end
      default: legal_o = 1'b0;
    endcase
    muldiv_o = (opcode_i == OPCODE_RTYPE) && (funct7_i == FUNCT7_MULDIV);
    // M-extension encodings are only legal when the mul/div unit exists.
    if (muldiv_o && !EN_MULDIV) legal_o = 1'b0;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control: sequences FETCH/DECODE/EXEC/MEM/MULDIV/WB with
// bounded memory waits and trap reporting.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_MULDIV   = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [6:0]    opcode_i,
  input  logic [6:0]    funct7_i,
  input  logic          imem_ready_i,
  input  logic          dmem_ready_i,
  input  logic          muldiv_done_i,
  input  logic          trap_clear_i,
  output logic          imem_req_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic          ir_write_o,
  output logic          pc_write_o,
  output logic          pc_write_cond_o,
  output pc_sel_e       pc_sel_o,
  output logic          alu_src_b_o,
  output imm_sel_e      imm_sel_o,
  output alu_op_class_e alu_op_o,
  output wb_sel_e       wb_sel_o,
  output logic          reg_write_o,
  output logic          muldiv_start_o,
  output logic          trap_o,
  output logic [1:0]    trap_cause_o,
  output ctrl_state_e   state_o
);

  // A wait cycle at this count is the last one before the bus-error trap.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic [7:0]    wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          start_q, start_d;

  imm_sel_e      dec_imm;
  logic          dec_src_b;
  alu_op_class_e dec_alu;
  wb_sel_e       dec_wb;
  logic          dec_legal;
  logic          dec_muldiv;

  ctrl_opcode_decoder #(.EN_MULDIV(EN_MULDIV)) u_dec (
    .opcode_i    (opcode_i),
    .funct7_i    (funct7_i),
    .imm_sel_o   (dec_imm),
    .alu_src_b_o (dec_src_b),
    .alu_op_o    (dec_alu),
    .wb_sel_o    (dec_wb),
    .legal_o     (dec_legal),
    .muldiv_o    (dec_muldiv)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    cause_d         = cause_q;
    start_d         = 1'b0;
    imem_req_o      = 1'b0;
    dmem_req_o      = 1'b0;
    dmem_we_o       = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_sel_o        = PC_PLUS4;
    alu_src_b_o     = 1'b0;
    imm_sel_o       = IMM_NONE;
    alu_op_o        = ALU_NONE;
    wb_sel_o        = WB_ALU;
    reg_write_o     = 1'b0;
    muldiv_start_o  = 1'b0;
    trap_o          = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WaitLast) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IBUS;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_muldiv) begin
          state_d = S_MULDIV;
          start_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_sel_o   = dec_imm;
        alu_src_b_o = dec_src_b;
        alu_op_o    = dec_alu;
        state_d     = S_WB;
        case (opcode_i)
          OPCODE_BRANCH: begin
            pc_write_cond_o = 1'b1;
            pc_sel_o        = PC_TARGET;
            state_d         = S_FETCH;
          end
          OPCODE_JAL:  begin pc_write_o = 1'b1; pc_sel_o = PC_TARGET; end
          OPCODE_JALR: begin pc_write_o = 1'b1; pc_sel_o = PC_JALR; end
          OPCODE_LOAD, OPCODE_STORE: state_d = S_MEM;
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (opcode_i == OPCODE_STORE);
        if (dmem_ready_i) begin
          state_d = (opcode_i == OPCODE_STORE) ? S_FETCH : S_WB;
        end else if (wait_q == WaitLast) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DBUS;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MULDIV: begin
        muldiv_start_o = start_q;
        if (muldiv_done_i) state_d = S_WB;
      end
      S_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = dec_wb;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        trap_o = 1'b1;
        if (trap_clear_i) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    // While reset is held the FETCH decode must not leak a request or strobe.
    if (!rst_ni) begin
      imem_req_o = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
    end
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction transaction
// model predicts every cycle's outputs; a second instance covers EN_MULDIV=0.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int TMO = 4;
  localparam int W   = 25;

  localparam logic [6:0] OP_LOAD = 7'h03, OP_I = 7'h13, OP_AUIPC = 7'h17, OP_STORE = 7'h23;
  localparam logic [6:0] OP_R = 7'h33, OP_LUI = 7'h37, OP_BR = 7'h63, OP_JALR = 7'h67;
  localparam logic [6:0] OP_JAL = 7'h6F;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_sel;
    logic       alu_src_b;
    logic [2:0] imm_sel;
    logic [2:0] alu_op;
    logic [1:0] wb_sel;
    logic       reg_write, muldiv_start, trap;
    logic [1:0] cause;
  } obs_t;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [6:0] opcode_i, funct7_i;
  logic imem_ready_i, dmem_ready_i, muldiv_done_i, trap_clear_i;
  logic imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_write_cond_o;
  pc_sel_e pc_sel_o;
  logic alu_src_b_o;
  imm_sel_e imm_sel_o;
  alu_op_class_e alu_op_o;
  wb_sel_e wb_sel_o;
  logic reg_write_o, muldiv_start_o, trap_o;
  logic [1:0] trap_cause_o;
  ctrl_state_e state_o;

  logic [6:0] nm_opcode_i, nm_funct7_i;
  logic nm_imem_ready_i, nm_dmem_ready_i, nm_muldiv_done_i, nm_trap_clear_i;
  logic nm_imem_req_o, nm_dmem_req_o, nm_dmem_we_o, nm_ir_write_o, nm_pc_write_o;
  logic nm_pc_write_cond_o;
  pc_sel_e nm_pc_sel_o;
  logic nm_alu_src_b_o;
  imm_sel_e nm_imm_sel_o;
  alu_op_class_e nm_alu_op_o;
  wb_sel_e nm_wb_sel_o;
  logic nm_reg_write_o, nm_muldiv_start_o, nm_trap_o;
  logic [1:0] nm_trap_cause_o;
  ctrl_state_e nm_state_o;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .EN_MULDIV(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct7_i(funct7_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .muldiv_done_i(muldiv_done_i), .trap_clear_i(trap_clear_i),
    .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .pc_sel_o(pc_sel_o), .alu_src_b_o(alu_src_b_o), .imm_sel_o(imm_sel_o),
    .alu_op_o(alu_op_o), .wb_sel_o(wb_sel_o), .reg_write_o(reg_write_o),
    .muldiv_start_o(muldiv_start_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .state_o(state_o)
  );

  multicycle_control_fsm #(.EN_MULDIV(1'b0)) dut_nm (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(nm_opcode_i), .funct7_i(nm_funct7_i),
    .imem_ready_i(nm_imem_ready_i), .dmem_ready_i(nm_dmem_ready_i),
    .muldiv_done_i(nm_muldiv_done_i), .trap_clear_i(nm_trap_clear_i),
    .imem_req_o(nm_imem_req_o), .dmem_req_o(nm_dmem_req_o), .dmem_we_o(nm_dmem_we_o),
    .ir_write_o(nm_ir_write_o), .pc_write_o(nm_pc_write_o),
    .pc_write_cond_o(nm_pc_write_cond_o), .pc_sel_o(nm_pc_sel_o),
    .alu_src_b_o(nm_alu_src_b_o), .imm_sel_o(nm_imm_sel_o), .alu_op_o(nm_alu_op_o),
    .wb_sel_o(nm_wb_sel_o), .reg_write_o(nm_reg_write_o),
    .muldiv_start_o(nm_muldiv_start_o), .trap_o(nm_trap_o),
    .trap_cause_o(nm_trap_cause_o), .state_o(nm_state_o)
  );

  obs_t act;
  assign act = {state_o, imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o,
                pc_write_cond_o, pc_sel_o, alu_src_b_o, imm_sel_o, alu_op_o, wb_sel_o,
                reg_write_o, muldiv_start_o, trap_o, trap_cause_o};

  // scoreboard
  logic [W-1:0] exp_q[$];
  obs_t want_c;
  int n_total = 0, n_bad = 0, ticks = 0;
  int regw_cnt = 0, dreq_cnt = 0, start_cnt = 0;
  logic [6:0] legal_ops [9] = '{OP_LOAD, OP_I, OP_AUIPC, OP_STORE, OP_R, OP_LUI, OP_BR,
                                OP_JALR, OP_JAL};

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      want_c = exp_q.pop_front();
      n_total++;
      if (act !== want_c) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got state=%0d vec=%h, want state=%0d vec=%h",
                 $time, act.state, act, want_c.state, want_c);
      end
    end
    if (reg_write_o) regw_cnt++;
    if (dmem_req_o) dreq_cnt++;
    if (muldiv_start_o) start_cnt++;
  end

  task automatic pin(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // reference model helpers
  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t exec_view(input logic [6:0] op);
    obs_t f;
    f = '0;
    f.state = S_EXEC;
    case (op)
      OP_R:     f.alu_op = ALU_RTYPE;
      OP_I:     begin f.imm_sel = IMM_I; f.alu_src_b = 1'b1; f.alu_op = ALU_ITYPE; end
      OP_LOAD:  begin f.imm_sel = IMM_I; f.alu_src_b = 1'b1; f.alu_op = ALU_ADD; end
      OP_STORE: begin f.imm_sel = IMM_S; f.alu_src_b = 1'b1; f.alu_op = ALU_ADD; end
      OP_BR: begin
        f.imm_sel = IMM_B; f.alu_op = ALU_BRANCH; f.pc_write_cond = 1'b1; f.pc_sel = PC_TARGET;
      end
      OP_JAL: begin
        f.imm_sel = IMM_J; f.alu_src_b = 1'b1; f.alu_op = ALU_ADD;
        f.pc_write = 1'b1; f.pc_sel = PC_TARGET;
      end
      OP_JALR: begin
        f.imm_sel = IMM_I; f.alu_src_b = 1'b1; f.alu_op = ALU_ADD;
        f.pc_write = 1'b1; f.pc_sel = PC_JALR;
      end
      OP_LUI:   begin f.imm_sel = IMM_U; f.alu_src_b = 1'b1; f.alu_op = ALU_LUI; end
      OP_AUIPC: begin f.imm_sel = IMM_U; f.alu_src_b = 1'b1; f.alu_op = ALU_ADD; end
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] wb_of(input logic [6:0] op);
    if (op == OP_LOAD) return WB_MEM;
    if (op == OP_JAL || op == OP_JALR) return WB_PC4;
    return WB_ALU;
  endfunction

  // driver tasks
  task automatic tick(input obs_t e);
    exp_q.push_back(e);
    ticks++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic noise();
    imem_ready_i  = 1'($urandom_range(0, 1));
    dmem_ready_i  = 1'($urandom_range(0, 1));
    muldiv_done_i = 1'($urandom_range(0, 1));
    trap_clear_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    obs_t e;
    rst_ni = 1'b0;
    for (int k = 0; k < n; k++) begin
      noise();
      imem_ready_i = 1'b1;
      e = '0;
      tick(e);
    end
    rst_ni = 1'b1;
  endtask

  task automatic trap_seq(input logic [1:0] cause, input int clr);
    obs_t e;
    for (int k = 0; k <= clr; k++) begin
      noise();
      trap_clear_i = (k == clr);
      e = '0; e.state = S_TRAP; e.trap = 1'b1; e.cause = cause;
      tick(e);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input int iw,
                           input int dw, input int mlat, input int clr, input int abort_at);
    obs_t e;
    for (int k = 0; k < TMO && k <= iw; k++) begin
      noise();
      opcode_i = 7'($urandom);
      funct7_i = 7'($urandom);
      imem_ready_i = (k == iw);
      e = '0; e.state = S_FETCH; e.imem_req = 1'b1;
      e.ir_write = (k == iw); e.pc_write = (k == iw);
      tick(e);
    end
    if (iw >= TMO) begin trap_seq(2'd2, clr); return; end
    noise();
    opcode_i = op;
    funct7_i = f7;
    e = '0; e.state = S_DECODE;
    tick(e);
    if (!is_legal(op)) begin trap_seq(2'd1, clr); return; end
    if (op == OP_R && f7 == 7'h01) begin
      for (int k = 0; k <= mlat; k++) begin
        noise();
        muldiv_done_i = (k == mlat);
        e = '0; e.state = S_MULDIV; e.muldiv_start = (k == 0);
        tick(e);
      end
    end else begin
      noise();
      tick(exec_view(op));
      if (op == OP_BR) return;
      if (op == OP_LOAD || op == OP_STORE) begin
        for (int k = 0; k < TMO && k <= dw; k++) begin
          if (k == abort_at) begin do_reset(2); return; end
          noise();
          dmem_ready_i = (k == dw);
          e = '0; e.state = S_MEM; e.dmem_req = 1'b1; e.dmem_we = (op == OP_STORE);
          tick(e);
        end
        if (dw >= TMO) begin trap_seq(2'd3, clr); return; end
        if (op == OP_STORE) return;
      end
    end
    noise();
    e = '0; e.state = S_WB; e.reg_write = 1'b1; e.wb_sel = wb_of(op);
    tick(e);
  endtask

  initial begin
    int t0, c0;
    int pick, iw, dw, mlat, clr;
    logic [6:0] op, f7;
    rst_ni = 1'b0;
    opcode_i = '0; funct7_i = '0;
    imem_ready_i = 1'b0; dmem_ready_i = 1'b0; muldiv_done_i = 1'b0; trap_clear_i = 1'b0;
    nm_opcode_i = '0; nm_funct7_i = '0;
    nm_imem_ready_i = 1'b0; nm_dmem_ready_i = 1'b0;
    nm_muldiv_done_i = 1'b0; nm_trap_clear_i = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset(3);

    t0 = ticks; c0 = regw_cnt;
    run_instr(OP_I, 7'h00, 0, 0, 0, 0, -1);
    pin("addi_cycles", ticks - t0, 4);
    pin("addi_regwrite_count", regw_cnt - c0, 1);

    t0 = ticks; c0 = dreq_cnt;
    run_instr(OP_LOAD, 7'h00, 0, 3, 0, 0, -1);
    pin("lw_wait3_cycles", ticks - t0, 8);
    pin("lw_dmem_req_count", dreq_cnt - c0, 4);

    t0 = ticks;
    run_instr(7'h7F, 7'h00, 0, 0, 0, 2, -1);
    pin("illegal_trap_cycles", ticks - t0, 5);

    t0 = ticks;
    run_instr(OP_I, 7'h00, TMO, 0, 0, 1, -1);
    pin("imem_timeout_cycles", ticks - t0, 6);

    t0 = ticks;
    run_instr(OP_I, 7'h00, TMO - 1, 0, 0, 0, -1);
    pin("imem_ready_last_wait_cycles", ticks - t0, 7);

    t0 = ticks; c0 = start_cnt;
    run_instr(OP_R, 7'h01, 0, 0, 4, 0, -1);
    pin("mul_cycles", ticks - t0, 8);
    pin("mul_start_pulses", start_cnt - c0, 1);

    t0 = ticks;
    run_instr(OP_R, 7'h01, 0, 0, 0, 0, -1);
    pin("mul_done_with_start_cycles", ticks - t0, 4);

    t0 = ticks;
    run_instr(OP_BR, 7'h00, 0, 0, 0, 0, -1);
    pin("branch_cycles", ticks - t0, 3);

    t0 = ticks;
    run_instr(OP_STORE, 7'h00, 0, 0, 0, 0, -1);
    pin("store_cycles", ticks - t0, 4);

    t0 = ticks;
    run_instr(OP_LOAD, 7'h00, 0, TMO, 0, 0, -1);
    pin("dmem_timeout_cycles", ticks - t0, 8);

    run_instr(OP_STORE, 7'h00, 0, 5, 0, 0, 2);
    run_instr(OP_JAL, 7'h00, 0, 0, 0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 11);
      op = (pick < 9) ? legal_ops[pick] : 7'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'h01;
      endcase
      iw   = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
      dw   = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
      mlat = $urandom_range(0, 6);
      clr  = $urandom_range(0, 3);
      run_instr(op, f7, iw, dw, mlat, clr, ($urandom_range(0, 15) == 0) ? 1 : -1);
    end

    do_reset(2);

    // EN_MULDIV=0, default 16-cycle timeout instance
    repeat (16) @(negedge clk_i);
    pin("nm_fetch_wait16_state", int'(nm_state_o), int'(S_FETCH));
    @(negedge clk_i);
    pin("nm_imem_timeout_state", int'(nm_state_o), int'(S_TRAP));
    pin("nm_imem_timeout_cause", int'(nm_trap_cause_o), 2);
    @(posedge clk_i); #1;
    nm_trap_clear_i = 1'b1;
    @(posedge clk_i); #1;
    nm_trap_clear_i = 1'b0;
    nm_imem_ready_i = 1'b1;
    @(negedge clk_i);
    pin("nm_fetch_after_clear", int'(nm_state_o), int'(S_FETCH));
    pin("nm_cause_cleared", int'(nm_trap_cause_o), 0);
    @(posedge clk_i); #1;
    nm_imem_ready_i = 1'b0;
    nm_opcode_i = OP_R;
    nm_funct7_i = 7'h01;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    pin("nm_mul_trap_state", int'(nm_state_o), int'(S_TRAP));
    pin("nm_mul_trap_cause", int'(nm_trap_cause_o), 1);
    pin("nm_mul_no_start", int'(nm_muldiv_start_o), 0);
    nm_trap_clear_i = 1'b1;
    @(posedge clk_i); #1;
    nm_trap_clear_i = 1'b0;
    nm_imem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    nm_imem_ready_i = 1'b0;
    nm_funct7_i = 7'h00;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    pin("nm_add_exec_state", int'(nm_state_o), int'(S_EXEC));
    pin("nm_add_exec_aluop", int'(nm_alu_op_o), int'(ALU_RTYPE));

    @(posedge clk_i); #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
